// File: rtl/dmem_port_arbiter_if.sv
// Two-requester data-memory bus plus the arbiter's BRAM pins.
// slave = arbiter side, master = requesters/BRAM side.
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;

   logic              busy;
   logic              owner;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_dout,
      output ack0, rdata0, ack1, rdata1,
      output mem_en, mem_we, mem_addr, mem_din,
      output busy, owner
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_dout,
      input  ack0, rdata0, ack1, rdata1,
      input  mem_en, mem_we, mem_addr, mem_din,
      input  busy, owner
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port req/ack arbiter in front of a single-port data BRAM.
// DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module dmem_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                 clock,
   input  logic                 rst,
   dmem_port_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   localparam logic [1:0] WAIT_N =
      (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

   state_t            state, state_n;
   logic [1:0]        cnt, cnt_n;
   logic              owner_q, owner_n;
   logic              we_q, we_n;
   logic              ack, rd_done, win;
   logic              en_n, mwe_n;
   logic [ADDR_W-1:0] maddr_n;
   logic [DATA_W-1:0] mdin_n;
   logic              mem_en_q, mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_din_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   always_comb win = ~bus.req0;
`else
   logic rr_ptr, rr_n;

   always_comb begin
      if (bus.req0 && bus.req1)
         win = rr_ptr;
      else
         win = bus.req1;
   end
`endif

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         owner_q    <= owner_n;
         we_q       <= we_n;
         mem_en_q   <= en_n;
         mem_we_q   <= mwe_n;
         mem_addr_q <= maddr_n;
         mem_din_q  <= mdin_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      owner_n = owner_q;
      we_n    = we_q;
      ack     = 1'b0;
      rd_done = 1'b0;
      en_n    = 1'b0;
      mwe_n   = 1'b0;
      maddr_n = '0;
      mdin_n  = '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      rr_n    = rr_ptr;
`endif
      unique case (state)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               owner_n = win;
               we_n    = win ? bus.we1 : bus.we0;
               state_n = ISSUE;
               en_n    = 1'b1;
               mwe_n   = we_n;
               maddr_n = win ? bus.addr1 : bus.addr0;
               mdin_n  = win ? bus.wdata1 : bus.wdata0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
               rr_n    = ~win;
`endif
            end
         end
         ISSUE: begin
            if (we_q) begin
               ack     = 1'b1;
               state_n = IDLE;
            end else if (RD_LAT == 1) begin
               state_n = DONE;
            end else begin
               state_n = WAIT;
               cnt_n   = WAIT_N;
            end
         end
         WAIT: begin
            if (cnt == 2'd0)
               state_n = DONE;
            else
               cnt_n = cnt - 2'd1;
         end
         DONE: begin
            ack     = 1'b1;
            rd_done = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

`ifndef DMEM_ARB_FIXED_PRIO_EN
   always_ff @(posedge clock or negedge rst) begin
      if (!rst)
         rr_ptr <= 1'b0;
      else
         rr_ptr <= rr_n;
   end
`endif

   // Read data is forwarded straight from the BRAM during DONE, then held.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (rd_done) begin
         if (owner_q)
            rdata1_q <= bus.mem_dout;
         else
            rdata0_q <= bus.mem_dout;
      end
   end

   assign bus.ack0     = ack & ~owner_q;
   assign bus.ack1     = ack & owner_q;
   assign bus.rdata0   = (rd_done && !owner_q) ? bus.mem_dout : rdata0_q;
   assign bus.rdata1   = (rd_done && owner_q) ? bus.mem_dout : rdata1_q;
   assign bus.mem_en   = mem_en_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_din  = mem_din_q;
   assign bus.busy     = (state != IDLE);
   assign bus.owner    = owner_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: one arbiter with RD_LAT=1, one with RD_LAT=3,
// each behind a small BRAM model.
module tb_dmem_port_arbiter;

   logic clock;
   logic rst;

   int checks;
   int errors;

   dmem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b ();
   dmem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) c ();

   dmem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) dut_b (
      .clock (clock),
      .rst   (rst),
      .bus   (b)
   );

   dmem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) dut_c (
      .clock (clock),
      .rst   (rst),
      .bus   (c)
   );

   logic [31:0] mem_b [256];
   logic [31:0] mem_c [256];
   logic [31:0] dout_b;
   logic [31:0] p0, p1, p2;

   always @(posedge clock) begin
      if (b.mem_en) begin
         if (b.mem_we) mem_b[b.mem_addr] <= b.mem_din;
         dout_b <= mem_b[b.mem_addr];
      end
   end
   assign b.mem_dout = dout_b;

   always @(posedge clock) begin
      if (c.mem_en) begin
         if (c.mem_we) mem_c[c.mem_addr] <= c.mem_din;
         p0 <= mem_c[c.mem_addr];
      end
      p1 <= p0;
      p2 <= p1;
   end
   assign c.mem_dout = p2;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      {b.req0, b.we0, b.addr0, b.wdata0} = '0;
      {b.req1, b.we1, b.addr1, b.wdata1} = '0;
      {c.req0, c.we0, c.addr0, c.wdata0} = '0;
      {c.req1, c.we1, c.addr1, c.wdata1} = '0;
      rst = 1'b0;
      #1;
      chk("rst_busy", 64'(b.busy), 64'd0);
      chk("rst_en", 64'(b.mem_en), 64'd0);
      chk("rst_ack", 64'({b.ack0, b.ack1}), 64'd0);
      chk("rst_rdata", 64'(b.rdata0 | b.rdata1), 64'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // port 0 write
      b.req0 = 1'b1; b.we0 = 1'b1;
      b.addr0 = 8'h10; b.wdata0 = 32'hDEADBEEF;
      tick();
      chk("wr_en", 64'(b.mem_en), 64'd1);
      chk("wr_we", 64'(b.mem_we), 64'd1);
      chk("wr_addr", 64'(b.mem_addr), 64'h10);
      chk("wr_din", 64'(b.mem_din), 64'hDEADBEEF);
      chk("wr_ack0", 64'(b.ack0), 64'd1);
      chk("wr_ack1", 64'(b.ack1), 64'd0);
      chk("wr_owner", 64'(b.owner), 64'd0);
      b.req0 = 1'b0;
      tick();
      chk("wr_idle", 64'(b.busy), 64'd0);
      chk("wr_en_lo", 64'(b.mem_en), 64'd0);

      // port 1 write 0x20, then read back 0x10
      b.req1 = 1'b1; b.we1 = 1'b1;
      b.addr1 = 8'h20; b.wdata1 = 32'h12345678;
      tick();
      chk("wr1_ack1", 64'(b.ack1), 64'd1);
      b.req1 = 1'b0;
      tick();
      b.req1 = 1'b1; b.we1 = 1'b0; b.addr1 = 8'h10;
      tick();
      chk("rd_en", 64'(b.mem_en), 64'd1);
      chk("rd_we", 64'(b.mem_we), 64'd0);
      chk("rd_addr", 64'(b.mem_addr), 64'h10);
      chk("rd_ack_early", 64'(b.ack1), 64'd0);
      b.req1 = 1'b0;
      b.addr1 = 8'h55;
      tick();
      chk("rd_ack1", 64'(b.ack1), 64'd1);
      chk("rd_ack0", 64'(b.ack0), 64'd0);
      chk("rd_rdata1", 64'(b.rdata1), 64'hDEADBEEF);
      chk("rd_rdata0", 64'(b.rdata0), 64'd0);
      chk("rd_en_lo", 64'(b.mem_en), 64'd0);
      tick();
      chk("rd_idle", 64'(b.busy), 64'd0);
      chk("rd_hold", 64'(b.rdata1), 64'hDEADBEEF);

      // reset while a read is in ISSUE
      b.req0 = 1'b1; b.we0 = 1'b0; b.addr0 = 8'h10;
      tick();
      chk("ab_en", 64'(b.mem_en), 64'd1);
      b.req0 = 1'b0;
      rst = 1'b0;
      #1;
      chk("ab_en_lo", 64'(b.mem_en), 64'd0);
      chk("ab_busy", 64'(b.busy), 64'd0);
      chk("ab_rdata", 64'(b.rdata1), 64'd0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("ab_noack", 64'({b.ack0, b.ack1}), 64'd0);
         chk("ab_idle", 64'(b.busy), 64'd0);
      end

      // contention, both reading, from reset
      rst = 1'b0;
      b.req0 = 1'b1; b.we0 = 1'b0; b.addr0 = 8'h10;
      b.req1 = 1'b1; b.we1 = 1'b0; b.addr1 = 8'h20;
      tick();
      rst = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         logic e0, e1;
         tick();
`ifdef DMEM_ARB_FIXED_PRIO_EN
         e0 = (k % 3 == 2);
         e1 = 1'b0;
`else
         e0 = (k % 6 == 2);
         e1 = (k % 6 == 5);
`endif
         chk($sformatf("rr_ack0_%0d", k), 64'(b.ack0), 64'(e0));
         chk($sformatf("rr_ack1_%0d", k), 64'(b.ack1), 64'(e1));
         if (e0) chk("rr_rdata0", 64'(b.rdata0), 64'hDEADBEEF);
         if (e1) chk("rr_rdata1", 64'(b.rdata1), 64'h12345678);
      end
      // lone request wins regardless of pointer
      b.req0 = 1'b0;
      tick();
      chk("lone_owner", 64'(b.owner), 64'd1);
      chk("lone_issue", 64'(b.mem_addr), 64'h20);
      tick();
      chk("lone_ack1", 64'(b.ack1), 64'd1);
      chk("lone_rdata1", 64'(b.rdata1), 64'h12345678);
      b.req1 = 1'b0;
      tick();

      // RD_LAT=3 instance
      c.req0 = 1'b1; c.we0 = 1'b1;
      c.addr0 = 8'h33; c.wdata0 = 32'hCAFEF00D;
      tick();
      chk("l3_wack", 64'(c.ack0), 64'd1);
      c.req0 = 1'b0;
      tick();
      c.req0 = 1'b1; c.we0 = 1'b0;
      tick();
      chk("l3_en", 64'(c.mem_en), 64'd1);
      chk("l3_addr", 64'(c.mem_addr), 64'h33);
      c.req0 = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         chk($sformatf("l3_wait_%0d", k), 64'(c.ack0), 64'd0);
         tick();
      end
      chk("l3_ack", 64'(c.ack0), 64'd1);
      chk("l3_rdata", 64'(c.rdata0), 64'hCAFEF00D);
      tick();
      chk("l3_idle", 64'(c.busy), 64'd0);

      c.req0 = 1'b1;
      tick();
      chk("l3r_en", 64'(c.mem_en), 64'd1);
      c.req0 = 1'b0;
      tick();
      chk("l3r_busy", 64'(c.busy), 64'd1);
      rst = 1'b0;
      #1;
      chk("l3r_en_lo", 64'(c.mem_en), 64'd0);
      chk("l3r_busy_lo", 64'(c.busy), 64'd0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("l3r_noack", 64'(c.ack0), 64'd0);
      end
      chk("l3r_rdata", 64'(c.rdata0), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
